// File: rtl/prm_oblgc_accum_if.sv
// Obstacle voxel stream between the voxel source and prm_oblgc_accum.
// The master drives beats; the slave returns ready.
interface prm_oblgc_accum_if #(
    parameter int unsigned OBS_W = 15
) ();
    logic             obs_valid;
    logic             obs_ready;
    logic [OBS_W-1:0] obs_data;
    logic             obs_last;

    modport master (
        output obs_valid,
        output obs_data,
        output obs_last,
        input  obs_ready
    );

    modport slave (
        input  obs_valid,
        input  obs_data,
        input  obs_last,
        output obs_ready
    );
endinterface

// File: rtl/prm_oblgc_accum.sv
// Buffers one frame of obstacle codes, presents each to the checker bank,
// and ORs the returned edge masks into a per-edge blocked bitmap.
module prm_oblgc_accum #(
    parameter int unsigned OBS_W      = 15,
    parameter int unsigned EDGE_NUM   = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                start,
    prm_oblgc_accum_if.slave    obs,
    output logic [OBS_W-1:0]    chk_code,
    input  logic [EDGE_NUM-1:0] chk_mask,
    output logic [EDGE_NUM-1:0] blocked_mask,
    output logic [CNT_W-1:0]    obs_count,
    output logic                busy,
    output logic                done
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e state_q, state_d;

    // FIFO entries carry {last, code}; pointers have one wrap bit.
    logic [OBS_W:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_idx, rd_idx;
    logic             fifo_full, fifo_empty;

    logic             push, pop, clear;
    logic             last_seen_q, last_seen_d;
    logic [OBS_W-1:0] chk_code_q, chk_code_d;
    logic             chk_vld_q, chk_vld_d;
    logic             chk_last_q, chk_last_d;
    logic [EDGE_NUM-1:0] blocked_q, blocked_d;
    logic [CNT_W-1:0]    count_q, count_d;

    assign wr_idx     = wr_ptr_q[PTR_W-1:0];
    assign rd_idx     = rd_ptr_q[PTR_W-1:0];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (wr_idx == rd_idx);

    assign obs.obs_ready = (state_q == StRun) && !fifo_full && !last_seen_q;
    assign push          = obs.obs_valid && obs.obs_ready;
    assign pop           = (state_q == StRun) && !fifo_empty;

    // The frame ends once the registered last code has been presented, so the
    // final fold into blocked_mask lands on the edge that enters StDrain.
    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    clear   = 1'b1;
                end
            end
            StRun: begin
                if (chk_vld_q && chk_last_q) begin
                    state_d = StDrain;
                end
            end
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        last_seen_d = last_seen_q;
        chk_code_d  = chk_code_q;
        chk_vld_d   = pop;
        chk_last_d  = 1'b0;
        if (clear) begin
            last_seen_d = 1'b0;
        end else if (push && obs.obs_last) begin
            last_seen_d = 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(1);
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + (PTR_W + 1)'(1);
            chk_code_d = mem_q[rd_idx][OBS_W-1:0];
            chk_last_d = mem_q[rd_idx][OBS_W];
        end
    end

    always_comb begin
        blocked_d = blocked_q;
        count_d   = count_q;
        if (clear) begin
            blocked_d = '0;
            count_d   = '0;
        end else if (chk_vld_q) begin
            blocked_d = blocked_q | chk_mask;
            if (count_q != {CNT_W{1'b1}}) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            last_seen_q <= 1'b0;
            chk_code_q  <= '0;
            chk_vld_q   <= 1'b0;
            chk_last_q  <= 1'b0;
            blocked_q   <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            last_seen_q <= last_seen_d;
            chk_code_q  <= chk_code_d;
            chk_vld_q   <= chk_vld_d;
            chk_last_q  <= chk_last_d;
            blocked_q   <= blocked_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: the pointers alone define validity.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_idx] <= {obs.obs_last, obs.obs_data};
        end
    end

    assign chk_code     = chk_code_q;
    assign blocked_mask = blocked_q;
    assign obs_count    = count_q;
    assign busy         = (state_q == StRun) || (state_q == StDrain);
    assign done         = (state_q == StDone);

endmodule

// File: tb/tb_prm_oblgc_accum.sv
// Randomized bench for prm_oblgc_accum: a behavioural checker bank drives
// chk_mask, and a frame-level model predicts codes, masks, counts and done.
module tb_prm_oblgc_accum;

    logic        CLK;
    logic        RST_N;
    logic        start;
    logic [14:0] chk_code;
    logic [15:0] chk_mask;
    logic [15:0] blocked_mask;
    logic [15:0] obs_count;
    logic        busy;
    logic        done;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [14:0] codes [$];

    prm_oblgc_accum_if #(.OBS_W(15)) obs_if ();

    prm_oblgc_accum #(
        .OBS_W(15),
        .EDGE_NUM(16),
        .FIFO_DEPTH(4),
        .CNT_W(16)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .start(start),
        .obs(obs_if),
        .chk_code(chk_code),
        .chk_mask(chk_mask),
        .blocked_mask(blocked_mask),
        .obs_count(obs_count),
        .busy(busy),
        .done(done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural checker bank: a few fixed codes, a simple hash elsewhere.
    function automatic logic [15:0] bank_fn(input logic [14:0] c);
        case (c)
            15'h4A21: return 16'h0005;
            15'h0101: return 16'h0001;
            15'h0202: return 16'h0100;
            15'h0303: return 16'h0000;
            15'h0404: return 16'h0101;
            15'h0505: return 16'h8000;
            15'h0606: return 16'h0002;
            default:  return c[4] ? 16'h0000 : ((16'h0001 << c[3:0]) | (16'h0001 << c[11:8]));
        endcase
    endfunction

    always_comb chk_mask = bank_fn(chk_code);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_code"}, 32'(chk_code), 0);
        check_eq({tag, "_blocked"}, 32'(blocked_mask), 0);
        check_eq({tag, "_count"}, 32'(obs_count), 0);
        check_eq({tag, "_ready"}, 32'(obs_if.obs_ready), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_done"}, 32'(done), 0);
    endtask

    // Runs the frame held in codes. Every accepted beat must reach chk_code
    // one edge later and blocked_mask/obs_count two edges later; done pulses
    // three edges after the last beat is accepted.
    task automatic run_frame(input string tag, input bit stray_start, input bit burst);
        logic        h0_v, h1_v, h2_v;
        logic [14:0] h0_c, h1_c, h2_c;
        logic [14:0] acc_code;
        logic [15:0] exp_blk, tot_blk;
        int          exp_cnt, idx, since_last, cyc;
        bit          acc;

        h0_v = 0; h1_v = 0; h2_v = 0;
        h0_c = '0; h1_c = '0; h2_c = '0;
        exp_blk = '0; exp_cnt = 0; idx = 0; since_last = -1; cyc = 0;

        @(negedge CLK);
        start = 1'b1;
        obs_if.obs_valid = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        check_eq({tag, "_start_busy"}, 32'(busy), 1);
        check_eq({tag, "_start_blocked"}, 32'(blocked_mask), 0);
        check_eq({tag, "_start_count"}, 32'(obs_count), 0);

        while (since_last < 5 && cyc < 300) begin
            if (idx < codes.size()) begin
                obs_if.obs_valid = burst ? 1'b1 : ($urandom_range(0, 3) != 0);
                obs_if.obs_data  = codes[idx];
                obs_if.obs_last  = (idx == codes.size() - 1);
                check_eq({tag, "_ready"}, 32'(obs_if.obs_ready), 1);
            end else begin
                obs_if.obs_valid = 1'($urandom_range(0, 1));
                obs_if.obs_data  = 15'($urandom);
                obs_if.obs_last  = 1'($urandom_range(0, 1));
                check_eq({tag, "_ready_off"}, 32'(obs_if.obs_ready), 0);
            end
            start = stray_start && (since_last < 4) && ($urandom_range(0, 4) == 0);
            acc      = (idx < codes.size()) && obs_if.obs_valid && obs_if.obs_ready;
            acc_code = obs_if.obs_data;

            @(negedge CLK);
            h2_v = h1_v; h2_c = h1_c;
            h1_v = h0_v; h1_c = h0_c;
            h0_v = acc;  h0_c = acc_code;
            if (acc) begin
                idx++;
                if (idx == codes.size()) since_last = 0;
            end else if (since_last >= 0) begin
                since_last++;
            end
            if (h1_v) check_eq({tag, "_chk_code"}, 32'(chk_code), 32'(h1_c));
            if (h2_v) begin
                exp_blk |= bank_fn(h2_c);
                exp_cnt++;
            end
            check_eq({tag, "_blocked_run"}, 32'(blocked_mask), 32'(exp_blk));
            check_eq({tag, "_count_run"}, 32'(obs_count), 32'(exp_cnt));
            check_eq({tag, "_done"}, 32'(done), 32'(since_last == 3));
            check_eq({tag, "_busy"}, 32'(busy), 32'(since_last < 3));
            cyc++;
        end
        start = 1'b0;
        obs_if.obs_valid = 1'b0;
        check_eq({tag, "_frame_timeout"}, 32'(since_last >= 5), 1);

        tot_blk = '0;
        foreach (codes[i]) tot_blk |= bank_fn(codes[i]);
        check_eq({tag, "_final_blocked"}, 32'(blocked_mask), 32'(tot_blk));
        check_eq({tag, "_final_count"}, 32'(obs_count), 32'(codes.size()));
    endtask

    task automatic reset_mid_frame();
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            obs_if.obs_valid = 1'b1;
            obs_if.obs_data  = 15'($urandom);
            obs_if.obs_last  = 1'b0;
            check_eq("midrst_ready", 32'(obs_if.obs_ready), 1);
            @(negedge CLK);
        end
        obs_if.obs_valid = 1'b0;
        RST_N = 1'b0;
        @(negedge CLK);
        check_all_zero("midrst");
        RST_N = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check_eq("midrst_no_done", 32'(done), 0);
            check_eq("midrst_idle", 32'(busy), 0);
        end
    endtask

    initial begin
        RST_N = 1'b0;
        start = 1'b1;
        obs_if.obs_valid = 1'b1;
        obs_if.obs_data  = 15'h1234;
        obs_if.obs_last  = 1'b1;
        repeat (3) @(negedge CLK);
        check_all_zero("rst_hold");
        RST_N = 1'b1;
        start = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            check_eq("post_rst_ready", 32'(obs_if.obs_ready), 0);
            check_eq("post_rst_busy", 32'(busy), 0);
            check_eq("post_rst_count", 32'(obs_count), 0);
        end
        obs_if.obs_valid = 1'b0;

        codes = '{15'h4A21};
        run_frame("single", 1'b0, 1'b1);

        codes = '{15'h0101, 15'h0202, 15'h0303, 15'h0404, 15'h0505};
        run_frame("multi_or", 1'b0, 1'b0);

        codes.delete();
        for (int i = 0; i < 20; i++) codes.push_back(15'($urandom));
        run_frame("burst", 1'b1, 1'b1);

        codes = '{15'h0606};
        run_frame("new_frame", 1'b1, 1'b0);

        reset_mid_frame();
        codes = '{15'h0404, 15'h0606, 15'h4A21, 15'h0505};
        run_frame("after_rst", 1'b0, 1'b0);

        for (int f = 0; f < 6; f++) begin
            codes.delete();
            for (int i = 0; i < int'($urandom_range(1, 12)); i++) codes.push_back(15'($urandom));
            run_frame("random", 1'b1, f[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
